// File: rtl/alu_seq_param.sv
// Parametrised handshaked ALU. Most ops finish in one cycle. Divide runs as an
// iterative restoring loop that retires one quotient bit per cycle, MSB first.
module alu_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic             OUT_VALID,
  output logic             FLAG_ZERO,
  output logic             FLAG_CARRY,
  output logic             FLAG_ERR
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dq_q, b_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_q, pend_carry, pend_err;
  logic [WIDTH-1:0] pend_lo, pend_hi;
  logic             accept, is_div, last_step;

  // Handshake: an op moves on a rising edge where IN_VALID && IN_READY; the
  // source holds A/B/ALU_FUN stable until then. Results have no backpressure.
  assign last_step = (state == DIV) && (cnt_q == CW'(WIDTH - 1));
  assign IN_READY  = ((state == IDLE) && !pend_q) || last_step;
  assign accept    = IN_VALID && IN_READY;
  assign is_div    = (ALU_FUN == 4'b0011) && (B != '0);

  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_dq;

  // dq_q starts as the dividend and is shifted out MSB-first while quotient
  // bits shift in at the LSB end.
  always_comb begin
    rem_sh   = {rem_q, dq_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    ge       = (rem_sh >= {1'b0, b_q});
    step_rem = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    step_dq  = {dq_q[WIDTH-2:0], ge};
  end

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_carry, res_err;

  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    prod      = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    res_lo    = '0;
    res_hi    = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (ALU_FUN)
      4'b0000: begin res_lo = sum[WIDTH-1:0]; res_carry = sum[WIDTH]; end
      4'b0001: begin res_lo = A - B; res_carry = (A < B); end
      4'b0010: begin
        res_lo    = prod[WIDTH-1:0];
        res_hi    = prod[2*WIDTH-1:WIDTH];
        res_carry = |prod[2*WIDTH-1:WIDTH];
      end
      4'b0011: begin res_lo = '1; res_hi = A; res_err = 1'b1; end
      4'b0100: res_lo = A & B;
      4'b0101: res_lo = A | B;
      4'b0110: res_lo = ~(A & B);
      4'b0111: res_lo = ~(A | B);
      4'b1000: res_lo = A ^ B;
      4'b1001: res_lo = ~(A ^ B);
      4'b1010: res_lo = (A == B) ? WIDTH'(1) : '0;
      4'b1011: res_lo = (A > B) ? WIDTH'(2) : '0;
      4'b1100: res_lo = (A < B) ? WIDTH'(3) : '0;
      4'b1101: res_lo = A >> 1;
      4'b1110: res_lo = A << 1;
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_div) state_next = DIV;
      DIV:     if (last_step) state_next = (accept && is_div) ? DIV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // A single-cycle op taken on the quotient's edge cannot share that edge's
  // output slot, so it is parked for one cycle and emitted right after.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dq_q       <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_lo    <= '0;
      pend_hi    <= '0;
      pend_carry <= 1'b0;
      pend_err   <= 1'b0;
      ALU_OUT    <= '0;
      ALU_OUT_HI <= '0;
      OUT_VALID  <= 1'b0;
      FLAG_ZERO  <= 1'b0;
      FLAG_CARRY <= 1'b0;
      FLAG_ERR   <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      pend_q    <= 1'b0;
      if (state == DIV) begin
        rem_q <= step_rem;
        dq_q  <= step_dq;
        cnt_q <= cnt_q + CW'(1);
        if (last_step) begin
          ALU_OUT    <= step_dq;
          ALU_OUT_HI <= step_rem;
          FLAG_ZERO  <= (step_dq == '0);
          FLAG_CARRY <= 1'b0;
          FLAG_ERR   <= 1'b0;
          OUT_VALID  <= 1'b1;
        end
      end
      if (pend_q) begin
        ALU_OUT    <= pend_lo;
        ALU_OUT_HI <= pend_hi;
        FLAG_ZERO  <= (pend_lo == '0);
        FLAG_CARRY <= pend_carry;
        FLAG_ERR   <= pend_err;
        OUT_VALID  <= 1'b1;
      end
      if (accept) begin
        if (is_div) begin
          dq_q  <= A;
          b_q   <= B;
          rem_q <= '0;
          cnt_q <= '0;
        end else if (state == DIV) begin
          pend_q     <= 1'b1;
          pend_lo    <= res_lo;
          pend_hi    <= res_hi;
          pend_carry <= res_carry;
          pend_err   <= res_err;
        end else begin
          ALU_OUT    <= res_lo;
          ALU_OUT_HI <= res_hi;
          FLAG_ZERO  <= (res_lo == '0);
          FLAG_CARRY <= res_carry;
          FLAG_ERR   <= res_err;
          OUT_VALID  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: a 16-bit instance for the main vectors and
// an 8-bit instance for the narrow-divide latency case.
module tb_alu_seq_param;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, flag_zero, flag_carry, flag_err;
  logic [3:0]  alu_fun;
  logic [15:0] a, b, alu_out, alu_out_hi;

  logic        in_valid_8, in_ready_8, out_valid_8, flag_zero_8, flag_carry_8, flag_err_8;
  logic [3:0]  alu_fun_8;
  logic [7:0]  a_8, b_8, alu_out_8, alu_out_hi_8;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_param #(.WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .ALU_FUN(alu_fun), .A(a), .B(b), .ALU_OUT(alu_out), .ALU_OUT_HI(alu_out_hi),
    .OUT_VALID(out_valid), .FLAG_ZERO(flag_zero), .FLAG_CARRY(flag_carry),
    .FLAG_ERR(flag_err)
  );

  alu_seq_param #(.WIDTH(8)) dut_8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid_8), .IN_READY(in_ready_8),
    .ALU_FUN(alu_fun_8), .A(a_8), .B(b_8), .ALU_OUT(alu_out_8),
    .ALU_OUT_HI(alu_out_hi_8), .OUT_VALID(out_valid_8), .FLAG_ZERO(flag_zero_8),
    .FLAG_CARRY(flag_carry_8), .FLAG_ERR(flag_err_8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    alu_fun  = f;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                              input logic z, input logic c, input logic e);
    check({tag, "_ov"},    out_valid,  1'b1);
    check({tag, "_out"},   alu_out,    lo);
    check({tag, "_hi"},    alu_out_hi, hi);
    check({tag, "_zero"},  flag_zero,  z);
    check({tag, "_carry"}, flag_carry, c);
    check({tag, "_err"},   flag_err,   e);
  endtask

  initial begin
    int ov_seen;
    int lat;
    rst = 1'b0; in_valid = 1'b0; alu_fun = '0; a = '0; b = '0;
    in_valid_8 = 1'b0; alu_fun_8 = '0; a_8 = '0; b_8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",   alu_out,    16'h0);
    check("rst_hi",    alu_out_hi, 16'h0);
    check("rst_ov",    out_valid,  1'b0);
    check("rst_ready", in_ready,   1'b1);
    check("rst_flags", {flag_zero, flag_carry, flag_err}, 3'b000);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(4'b0000, 16'hFFFF, 16'h0001);
    check_single("add", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_ov_drop", out_valid, 1'b0);
    check("add_hold",    {alu_out, flag_zero, flag_carry}, {16'h0000, 2'b11});

    // back-to-back sub then mul
    alu_fun = 4'b0001; a = 16'd5; b = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    check_single("sub", 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0);
    alu_fun = 4'b0010; a = 16'h1234; b = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_single("mul", 16'h0060, 16'h0626, 1'b0, 1'b1, 1'b0);

    // divide 1000/7 with a second divide 100/9 held during DIV
    issue(4'b0011, 16'd1000, 16'd7);
    alu_fun = 4'b0011; a = 16'd100; b = 16'd9; in_valid = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (in_ready !== 1'b0) begin
        check($sformatf("div_ready_low_%0d", i), in_ready, 1'b0);
      end
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
    end
    check("div_busy_no_ov", ov_seen, 0);
    check("div_ready_last", in_ready, 1'b1);
    check("div_ov_early",   out_valid, 1'b0);
    @(posedge clk); #1;
    check_single("div", 16'd142, 16'd6, 1'b0, 1'b0, 1'b0);
    check("div2_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("div2_ov_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check_single("div2", 16'd11, 16'd1, 1'b0, 1'b0, 1'b0);

    issue(4'b0011, 16'h00AB, 16'h0000);
    check_single("div0", 16'hFFFF, 16'h00AB, 1'b0, 1'b0, 1'b1);
    check("div0_ready", in_ready, 1'b1);

    issue(4'b1010, 16'd9, 16'd9);
    check_single("eq", 16'd1, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b1100, 16'd3, 16'd9);
    check_single("lt", 16'd3, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b1011, 16'd3, 16'd9);
    check_single("gt", 16'd0, 16'h0, 1'b1, 1'b0, 1'b0);
    issue(4'b1110, 16'h8001, 16'h0);
    check_single("shl", 16'h0002, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b1101, 16'h8001, 16'h0);
    check_single("shr", 16'h4000, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b0110, 16'hF0F0, 16'hFF00);
    check_single("nand", 16'h0FFF, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b1001, 16'hF0F0, 16'hFF00);
    check_single("xnor", 16'hF00F, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(4'b1111, 16'h1234, 16'h5678);
    check_single("illegal", 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);

    // reset five cycles into a divide
    issue(4'b0011, 16'd1000, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out",   {alu_out, alu_out_hi}, 32'h0);
    check("mid_rst_flags", {flag_zero, flag_carry, flag_err}, 3'b000);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_ov",    out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    ov_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("mid_rst_no_ov", ov_seen, 0);
    issue(4'b0000, 16'd2, 16'd3);
    check_single("post_rst_add", 16'd5, 16'h0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 divide 200/3
    alu_fun_8 = 4'b0011; a_8 = 8'd200; b_8 = 8'd3; in_valid_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    lat = 0;
    while (!out_valid_8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", lat, 8);
    check("w8_quot",    alu_out_8, 8'd66);
    check("w8_rem",     alu_out_hi_8, 8'd2);
    check("w8_err",     flag_err_8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised, handshaked successor to the team's 16-bit registered ALU, with the same 4-bit function encoding.
- Operand width is a parameter.
- Multiply returns the full double-width product.
- Divide is an iterative restoring divider producing quotient and remainder.
- Adds status flags and a valid/ready input handshake so a datapath controller can issue one operation per cycle except while a divide is in flight.

Parameters:
WIDTH, 16, operand and result width in bits (legal range 4..32)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
IN_VALID  input  1  operands and function are valid this cycle
IN_READY  output  1  block can accept an operation this cycle
ALU_FUN  input  4  function select
A  input  WIDTH  operand A (unsigned)
B  input  WIDTH  operand B (unsigned)
ALU_OUT  output  WIDTH  primary result (low product / quotient)
ALU_OUT_HI  output  WIDTH  high product / remainder; 0 for other ops
OUT_VALID  output  1  one-cycle pulse; result and flags valid
FLAG_ZERO  output  1  ALU_OUT == 0
FLAG_CARRY  output  1  add carry-out / sub borrow / product high half nonzero
FLAG_ERR  output  1  divide by zero or illegal ALU_FUN

Behaviour:
- Reset (RST low, async):
  - All outputs go to 0 except IN_READY, which goes to 1.
  - FSM goes to IDLE and any in-flight divide is discarded with no OUT_VALID.
  - Outputs stay at 0 until the next OUT_VALID.
- Accept: an operation is taken on a rising edge where IN_VALID && IN_READY. A, B and ALU_FUN are sampled only at that edge.
- FSM states are IDLE and DIV.
  - IN_READY = 1 in IDLE. IN_READY = 1 in DIV only on its final step cycle, so the next operation issues right after the quotient.
- Single-cycle ops (everything except 0011 with B != 0):
  - Result, flags and OUT_VALID are registered at the accepting edge, so OUT_VALID is high in the following cycle.
  - FSM stays in IDLE, giving throughput of one operation per cycle.
- Function encoding, all arithmetic unsigned and mod 2^WIDTH unless stated:
  - 0000 add: CARRY = bit WIDTH of A+B.
  - 0001 sub: CARRY = borrow (A < B).
  - 0010 mul: full 2*WIDTH product; {ALU_OUT_HI, ALU_OUT} = A*B; CARRY = |ALU_OUT_HI.
  - 0011 div: see below.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR.
  - 1010: result = 1 if A == B, else 0.
  - 1011: result = 2 if A > B, else 0.
  - 1100: result = 3 if A < B, else 0.
  - 1101: A >> 1, logical. 1110: A << 1, MSB dropped.
  - 1111 illegal: ALU_OUT = 0, ERR = 1.
  - CARRY = 0 for all ops other than add, sub and mul.
  - ERR = 0 for all ops other than divide by zero and 1111.
  - ALU_OUT_HI = 0 for all ops other than mul and div.
- Divide, B != 0:
  - At the accepting edge the divider latches A and B, clears the remainder and step counter, and the FSM enters DIV.
  - Each following edge performs one restoring step, MSB first. There are exactly WIDTH steps.
  - The edge performing step WIDTH registers ALU_OUT = quotient, ALU_OUT_HI = remainder, flags and OUT_VALID, and the FSM returns to IDLE.
  - Latency is WIDTH edges from acceptance to the OUT_VALID-registering edge; issue-to-issue spacing is WIDTH cycles.
  - IN_VALID during the non-final DIV cycles is not accepted; the source must hold its operation.
- Divide by zero:
  - Handled as a single-cycle op with no DIV entry.
  - ALU_OUT = all ones, ALU_OUT_HI = A, ERR = 1.
- Flags:
  - FLAG_ZERO reflects ALU_OUT only. For mul, ZERO reflects the low half only.
  - Flags update only on OUT_VALID edges.
- Output hold: ALU_OUT, ALU_OUT_HI and the flags hold their last values while OUT_VALID = 0. OUT_VALID is never high for two consecutive cycles from a single operation.
- No output backpressure: the consumer must take the result on the OUT_VALID cycle.

Test Plan:
- Reset then add, WIDTH=16: A=0xFFFF, B=0x0001, FUN=0000 -> next cycle OUT_VALID=1, ALU_OUT=0x0000, ZERO=1, CARRY=1, ERR=0.
- Back-to-back issue: sub 5-7 then mul 0x1234*0x5678 on consecutive cycles -> OUT_VALID on two consecutive cycles:
  - sub: ALU_OUT=0xFFFE, CARRY=1.
  - mul: ALU_OUT=0x0060, ALU_OUT_HI=0x0626, CARRY=1.
- Divide: A=1000, B=7 -> IN_READY low for 15 cycles; OUT_VALID exactly 16 cycles after the accepting edge with ALU_OUT=142, ALU_OUT_HI=6, ERR=0. An IN_VALID held during DIV is accepted on the OUT_VALID cycle's edge.
- Divide by zero: A=0x00AB, B=0 -> next cycle ALU_OUT=0xFFFF, ALU_OUT_HI=0x00AB, ERR=1, IN_READY stays 1.
- Compares, shifts and illegal op:
  - A=B=9, FUN=1010 -> 1.
  - A=3, B=9, FUN=1100 -> 3; same operands, FUN=1011 -> 0 with ZERO=1.
  - A=0x8001, FUN=1110 -> 0x0002.
  - FUN=1111 -> ALU_OUT=0, ERR=1.
- Reset mid-divide: assert RST 5 cycles into a divide -> outputs 0, IN_READY=1 immediately, no OUT_VALID after release. A new add issued after release completes with latency 1. Repeat with WIDTH=8: divide 200/3 -> ALU_OUT=66, ALU_OUT_HI=2, latency 8.
